lifo_stack: RTL and testbench

- Parametrised last-in/first-out stack with configurable data width and depth.
- Adds to the earlier fixed 4-bit stack: explicit push/pop strobes, same-cycle push+pop (replace top), combinational peek of the top entry, occupancy count, flush, and overflow/underflow reporting.
- Sits between a producer and a consumer in the same clock domain. Used as a return-address or operand stack in small controllers.

---
 rtl/lifo_stack_if.sv | 41 ++++
 rtl/lifo_stack.sv | 118 +++++++++++
 tb/tb_lifo_stack.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lifo_stack_if.sv
// Bundle of the LIFO stack's data-path and status signals.
// The producer/consumer side uses the master modport; the stack uses slave.
//
// Handshake: push and pop are single-cycle strobes sampled on the rising
// edge. There is no ready signal. The stack always accepts a strobe.
// full and empty tell the caller whether that strobe will take effect.
// A rejected push or pop is reported by a one-cycle overflow or underflow
// pulse and is also latched into err_sticky.
// dout_valid qualifies dout for exactly one cycle per successful pop.
interface lifo_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clear;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic              err_sticky;

  modport master (
    output clear, push, pop, din,
    input  dout, dout_valid, top, count, empty, full,
           overflow, underflow, err_sticky
  );

  modport slave (
    input  clear, push, pop, din,
    output dout, dout_valid, top, count, empty, full,
           overflow, underflow, err_sticky
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack for return-address or operand storage.
// mem[0] is the bottom entry and the top entry is mem[count-1].
// Doing push and pop in the same cycle replaces the top entry.
// dout is a registered copy of each popped word.
// top is a combinational peek at the current top entry.
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input logic         clk,
  input logic         rst,
  lifo_stack_if.slave bus
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              err_q;

  logic              is_empty;
  logic              is_full;
  logic [ADDR_W-1:0] cnt_lo;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              push_ok;
  logic              pop_ok;
  logic              overflow_nxt;
  logic              underflow_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(DEPTH));

  // cnt - 1 always fits in ADDR_W bits whenever the stack is non-empty.
  // Wrapping in the narrow domain therefore gives the right top index.
  assign cnt_lo  = cnt[ADDR_W-1:0];
  assign top_idx = cnt_lo - ADDR_W'(1);

  // Decide what this cycle's strobes do. A pop is legal whenever the stack
  // is non-empty. A push is legal when there is room, or when a legal pop in
  // the same cycle frees the top slot (the replace case).
  always_comb begin
    pop_ok        = bus.pop && !is_empty;
    push_ok       = bus.push && (!is_full || pop_ok);
    overflow_nxt  = bus.push && !push_ok;
    underflow_nxt = bus.pop && is_empty;
    wr_idx        = pop_ok ? top_idx : cnt_lo;
    cnt_nxt       = cnt;
    if (push_ok && !pop_ok) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Occupancy, popped-word register and error flags. rst wins over clear,
  // and clear wins over push/pop. dout holds its value through a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      err_q        <= 1'b0;
    end else if (bus.clear) begin
      cnt          <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dout_valid_q <= pop_ok;
      overflow_q   <= overflow_nxt;
      underflow_q  <= underflow_nxt;
      if (overflow_nxt || underflow_nxt) begin
        err_q <= 1'b1;
      end
      if (pop_ok) begin
        dout_q <= mem[top_idx];
      end
    end
  end

  // Storage write. push_ok guarantees that wr_idx lies within 0..DEPTH-1.
  // The stored data needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clear && push_ok) begin
      mem[wr_idx] <= bus.din;
    end
  end

  assign bus.count      = cnt;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.top        = is_empty ? '0 : mem[top_idx];
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.err_sticky = err_q;

  // Occupancy can never leave 0..DEPTH.
  count_in_range: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_W'(DEPTH));

  // The two error pulses come from opposite conditions, but both can
  // coincide only when push is rejected while the stack is empty. That is
  // impossible, because an empty stack is never full.
  no_dual_error: assert property (@(posedge clk) disable iff (rst)
    !(overflow_q && underflow_q));
endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack.
// Two instances are built: DEPTH=4 and DEPTH=5, both with DATA_W=8.
// Both instances receive the same stimulus. Only the instance selected by
// `cur` is compared.
module tb_lifo_stack;
  logic clk;
  logic rst;
  logic t_clear, t_push, t_pop;
  logic [7:0] t_din;

  int n_checks = 0;
  int n_err    = 0;
  int cur      = 4;

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  lifo_stack_if #(.DATA_W(8), .DEPTH(4)) if4 ();
  lifo_stack_if #(.DATA_W(8), .DEPTH(5)) if5 ();

  assign if4.clear = t_clear;
  assign if4.push  = t_push;
  assign if4.pop   = t_pop;
  assign if4.din   = t_din;
  assign if5.clear = t_clear;
  assign if5.push  = t_push;
  assign if5.pop   = t_pop;
  assign if5.din   = t_din;

  lifo_stack #(.DATA_W(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  lifo_stack #(.DATA_W(8), .DEPTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  // Outputs of the currently selected instance.
  logic [7:0]  a_dout, a_top;
  logic [31:0] a_cnt;
  logic        a_dv, a_full, a_empty, a_ovf, a_unf, a_err;
  always_comb begin
    a_dout  = if4.dout;
    a_top   = if4.top;
    a_cnt   = 32'(if4.count);
    a_dv    = if4.dout_valid;
    a_full  = if4.full;
    a_empty = if4.empty;
    a_ovf   = if4.overflow;
    a_unf   = if4.underflow;
    a_err   = if4.err_sticky;
    if (cur == 5) begin
      a_dout  = if5.dout;
      a_top   = if5.top;
      a_cnt   = 32'(if5.count);
      a_dv    = if5.dout_valid;
      a_full  = if5.full;
      a_empty = if5.empty;
      a_ovf   = if5.overflow;
      a_unf   = if5.underflow;
      a_err   = if5.err_sticky;
    end
  end

  // Reference model. The stack is a queue, and its back is the top entry.
  logic [7:0] mq[$];
  int         m_depth = 4;
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_unf, m_err;

  function automatic void model_step(logic r, logic c, logic pu, logic po, logic [7:0] d);
    if (r) begin
      mq.delete();
      m_dout = 8'h00; m_dv = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    end else if (c) begin
      mq.delete();
      m_dv = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    end else begin
      m_dv = 0; m_ovf = 0; m_unf = 0;
      if (po && mq.size() > 0) begin
        m_dout = mq.pop_back();
        m_dv   = 1;
        if (pu) mq.push_back(d);
      end else begin
        if (po) m_unf = 1;
        if (pu) begin
          if (mq.size() < m_depth) mq.push_back(d);
          else m_ovf = 1;
        end
      end
      if (m_ovf || m_unf) m_err = 1;
    end
  endfunction

  // Scoreboard helpers.
  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_dout, input logic e_dv,
                           input logic [7:0] e_top, input int e_cnt, input logic e_full,
                           input logic e_empty, input logic e_ovf, input logic e_unf,
                           input logic e_err);
    chk(tag, "dout", 32'(a_dout), 32'(e_dout));
    chk(tag, "dout_valid", 32'(a_dv), 32'(e_dv));
    chk(tag, "top", 32'(a_top), 32'(e_top));
    chk(tag, "count", a_cnt, 32'(e_cnt));
    chk(tag, "full", 32'(a_full), 32'(e_full));
    chk(tag, "empty", 32'(a_empty), 32'(e_empty));
    chk(tag, "overflow", 32'(a_ovf), 32'(e_ovf));
    chk(tag, "underflow", 32'(a_unf), 32'(e_unf));
    chk(tag, "err_sticky", 32'(a_err), 32'(e_err));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_dout, m_dv, (mq.size() > 0) ? mq[$] : 8'h00, mq.size(),
              mq.size() == m_depth, mq.size() == 0, m_ovf, m_unf, m_err);
  endtask

  // Driver: apply one cycle of inputs, then settle #1 past the edge.
  task automatic step(input logic r, input logic c, input logic pu, input logic po, input logic [7:0] d);
    rst = r; t_clear = c; t_push = pu; t_pop = po; t_din = d;
    @(posedge clk);
    #1;
    model_step(r, c, pu, po, d);
  endtask

  // Directed vector table.
  typedef struct {
    logic r, c, pu, po;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic e_dv;
    logic [7:0] e_top;
    int   e_cnt;
    logic e_full, e_empty, e_ovf, e_unf, e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic c, logic pu, logic po, logic [7:0] din,
                              logic [7:0] e_dout, logic e_dv, logic [7:0] e_top, int e_cnt,
                              logic e_full, logic e_empty, logic e_ovf, logic e_unf, logic e_err);
    vec_t v;
    v.r = r; v.c = c; v.pu = pu; v.po = po; v.din = din;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_top = e_top; v.e_cnt = e_cnt;
    v.e_full = e_full; v.e_empty = e_empty; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_err = e_err;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; t_clear = 0; t_push = 0; t_pop = 0; t_din = 0;

    //   r c pu po din    dout dv top cnt full empty ovf unf err
    add(1,0,0,0,8'h00, 8'h00,0,8'h00,0, 0,1,0,0,0);  // reset
    add(0,0,1,0,8'h11, 8'h00,0,8'h11,1, 0,0,0,0,0);  // fill
    add(0,0,1,0,8'h22, 8'h00,0,8'h22,2, 0,0,0,0,0);
    add(0,0,1,0,8'h33, 8'h00,0,8'h33,3, 0,0,0,0,0);
    add(0,0,1,0,8'h44, 8'h00,0,8'h44,4, 1,0,0,0,0);
    add(0,0,1,0,8'h55, 8'h00,0,8'h44,4, 1,0,1,0,1);  // overflow
    add(0,0,0,0,8'h00, 8'h00,0,8'h44,4, 1,0,0,0,1);  // pulse ends, sticky stays
    add(0,0,0,1,8'h00, 8'h44,1,8'h33,3, 0,0,0,0,1);  // drain
    add(0,0,0,1,8'h00, 8'h33,1,8'h22,2, 0,0,0,0,1);
    add(0,0,0,1,8'h00, 8'h22,1,8'h11,1, 0,0,0,0,1);
    add(0,0,0,1,8'h00, 8'h11,1,8'h00,0, 0,1,0,0,1);
    add(0,0,0,1,8'h00, 8'h11,0,8'h00,0, 0,1,0,1,1);  // underflow, dout kept
    add(0,0,0,0,8'h00, 8'h11,0,8'h00,0, 0,1,0,0,1);
    add(0,1,0,0,8'h00, 8'h11,0,8'h00,0, 0,1,0,0,0);  // clear
    add(0,0,1,0,8'hA0, 8'h11,0,8'hA0,1, 0,0,0,0,0);
    add(0,0,1,0,8'hB0, 8'h11,0,8'hB0,2, 0,0,0,0,0);
    add(0,0,1,1,8'hC0, 8'hB0,1,8'hC0,2, 0,0,0,0,0);  // replace
    add(0,0,1,0,8'hD0, 8'hB0,0,8'hD0,3, 0,0,0,0,0);
    add(0,0,1,0,8'hE0, 8'hB0,0,8'hE0,4, 1,0,0,0,0);
    add(0,0,1,1,8'hF0, 8'hE0,1,8'hF0,4, 1,0,0,0,0);  // replace while full
    add(0,1,0,0,8'h00, 8'hE0,0,8'h00,0, 0,1,0,0,0);
    add(0,0,1,1,8'h7E, 8'hE0,0,8'h7E,1, 0,0,0,1,1);  // push+pop on empty
    add(0,0,1,0,8'h01, 8'hE0,0,8'h01,2, 0,0,0,0,1);
    add(0,0,1,0,8'h02, 8'hE0,0,8'h02,3, 0,0,0,0,1);
    add(0,1,1,0,8'h99, 8'hE0,0,8'h00,0, 0,1,0,0,0);  // clear beats push
    add(0,0,1,0,8'h5A, 8'hE0,0,8'h5A,1, 0,0,0,0,0);
    add(0,0,0,1,8'h00, 8'h5A,1,8'h00,0, 0,1,0,0,0);
    add(0,0,0,1,8'h00, 8'h5A,0,8'h00,0, 0,1,0,1,1);
    add(0,0,1,0,8'h12, 8'h5A,0,8'h12,1, 0,0,0,0,1);
    add(0,0,1,0,8'h34, 8'h5A,0,8'h34,2, 0,0,0,0,1);
    add(0,0,1,0,8'h56, 8'h5A,0,8'h56,3, 0,0,0,0,1);
    add(1,0,1,0,8'h78, 8'h00,0,8'h00,0, 0,1,0,0,0);  // reset beats push
    add(0,0,0,1,8'h00, 8'h00,0,8'h00,0, 0,1,0,1,1);  // first pop after reset

    cur = 4; m_depth = 4;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].pu, tbl[i].po, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_dv, tbl[i].e_top, tbl[i].e_cnt,
                tbl[i].e_full, tbl[i].e_empty, tbl[i].e_ovf, tbl[i].e_unf, tbl[i].e_err);
    end

    // DEPTH=5: full at exactly five entries, then reverse-order drain.
    cur = 5; m_depth = 5;
    step(1, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 0, 8'(k));
      if (k <= 5)
        check_all($sformatf("d5_push%0d", k), 8'h00, 0, 8'(k), k, k == 5, 0, 0, 0, 0);
      else
        check_all("d5_push6", 8'h00, 0, 8'h05, 5, 1, 0, 1, 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 8'h00);
      check_all($sformatf("d5_pop%0d", i), 8'(5 - i), 1, (i < 4) ? 8'(4 - i) : 8'h00,
                4 - i, 0, i == 4, 0, 0, 1);
    end

    // Randomized phase, compared against the queue model for both depths.
    for (int d = 4; d <= 5; d++) begin
      cur = d; m_depth = d;
      step(1, 0, 0, 0, 8'h00);
      check_model($sformatf("rand%0d_reset", d));
      for (int n = 0; n < 400; n++) begin
        int bias;
        logic r, c, pu, po;
        bias = ((n / 40) % 2 == 0) ? 75 : 25;
        r  = ($urandom_range(0, 149) == 0);
        c  = ($urandom_range(0, 39) == 0);
        pu = ($urandom_range(0, 99) < bias);
        po = ($urandom_range(0, 99) < (100 - bias));
        step(r, c, pu, po, 8'($urandom));
        check_model($sformatf("rand%0d_%0d", d, n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
